// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmitter and receiver: default widths,
// controller state encoding and word-select polarity.
package i2s_pkg;

   localparam int I2S_NUMBER_OF_BITS = 8;
   localparam int I2S_SLOT_BITS      = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_state_e;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clock_gen.sv
// SCK divider: toggles sck every SCK_DIV clk cycles while enabled, held at 0 otherwise.
// Tick strobes are asserted in the cycle before sck changes so that users update together with sck.
module i2s_clock_gen #(
   parameter int SCK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DW = $clog2(SCK_DIV) + 1;

   logic [DW-1:0] div_q, div_d;
   logic          sck_q, sck_d;
   logic          tc;

   assign tc = en_i && (div_q == DW'(SCK_DIV - 1));

   always_comb begin
      div_d = div_q;
      sck_d = sck_q;
      if (!en_i) begin
         div_d = '0;
         sck_d = 1'b0;
      end else if (tc) begin
         div_d = '0;
         sck_d = ~sck_q;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         sck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         sck_q <= sck_d;
      end
   end

   assign sck_o  = sck_q;
   assign rise_o = tc && !sck_q;
   assign fall_o = tc && sck_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S bus master transmitter: one-pair holding register feeding a frame shifter
// that drives Philips I2S (WS leads the MSB by one SCK).
module i2s_transmitter
   import i2s_pkg::*;
#(
   parameter int NUMBER_OF_BITS = I2S_NUMBER_OF_BITS,
   parameter int SLOT_BITS      = I2S_SLOT_BITS,
   parameter int SCK_DIV        = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [NUMBER_OF_BITS-1:0] sample_left,
   input  logic [NUMBER_OF_BITS-1:0] sample_right,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   output logic                      sck,
   output logic                      ws,
   output logic                      sd,
   output logic                      frame_start,
   output logic                      underrun
);

   localparam int FW = 2 * SLOT_BITS;
   localparam int PW = $clog2(FW);

   generate
      if (NUMBER_OF_BITS > SLOT_BITS) begin : g_bad_width
         $error("i2s_transmitter: NUMBER_OF_BITS must not exceed SLOT_BITS");
      end
      if (SCK_DIV < 1) begin : g_bad_div
         $error("i2s_transmitter: SCK_DIV must be at least 1");
      end
   endgenerate

   i2s_state_e                state_q, state_d;
   logic                      full_q, full_d, ready_q;
   logic [NUMBER_OF_BITS-1:0] left_q, right_q;
   logic [FW-1:0]             frame_q, packed_pair;
   logic [PW-1:0]             p_q;
   logic                      ws_q, fs_q, ur_q;
   logic                      sck_w, fall_w, rise_unused;
   logic                      accept, wrap, load, underrun_d;

   i2s_clock_gen #(.SCK_DIV(SCK_DIV)) u_clk_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (state_q == RUN),
      .sck_o  (sck_w),
      .rise_o (rise_unused),
      .fall_o (fall_w)
   );

   function automatic logic ws_at(input logic [PW-1:0] p);
      return (((int'(p) + 1) % FW) >= SLOT_BITS) ? WS_RIGHT : WS_LEFT;
   endfunction

   // Frame image {left, pad, right, pad}; shifted out MSB first, zeros shift in.
   assign packed_pair = (FW'(left_q) << (FW - NUMBER_OF_BITS)) |
                        (FW'(right_q) << (SLOT_BITS - NUMBER_OF_BITS));
   assign wrap        = fall_w && (p_q == PW'(FW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en && full_q) state_d = RUN;
         RUN:     if (wrap && !en)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept     = sample_valid && ready_q;
      load       = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         IDLE: load = en && full_q;
         RUN: begin
            load       = wrap && en;
            underrun_d = wrap && en && !full_q;
         end
         default: ;
      endcase
      full_d = full_q;
      if (accept)    full_d = 1'b1;
      else if (load) full_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         ready_q <= 1'b1;
         left_q  <= '0;
         right_q <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= !full_d;
         if (accept) begin
            left_q  <= sample_left;
            right_q <= sample_right;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
         p_q     <= '0;
         ws_q    <= WS_LEFT;
         fs_q    <= 1'b0;
         ur_q    <= 1'b0;
      end else begin
         fs_q <= load;
         ur_q <= underrun_d;
         if (load) begin
            frame_q <= full_q ? packed_pair : '0;
            p_q     <= '0;
            ws_q    <= ws_at('0);
         end else if (state_q == RUN && wrap) begin
            frame_q <= '0;
            p_q     <= '0;
            ws_q    <= WS_LEFT;
         end else if (fall_w) begin
            frame_q <= {frame_q[FW-2:0], 1'b0};
            p_q     <= p_q + 1'b1;
            ws_q    <= ws_at(p_q + 1'b1);
         end
      end
   end

   assign sample_ready = ready_q;
   assign sck          = sck_w;
   assign ws           = ws_q;
   assign sd           = frame_q[FW-1];
   assign frame_start  = fs_q;
   assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench: default-parameter transmitter plus a SCK_DIV=1/SLOT_BITS=8 copy looped into a bench-side receiver.
module tb_i2s_transmitter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en, sv, ready, sck, ws, sd, fs, ur;
   logic [7:0] sl, sr;
   logic       lb_en, lb_v, lb_ready, lb_sck, lb_ws, lb_sd, lb_fs, lb_ur;
   logic [7:0] lb_l, lb_r;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2s_transmitter dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .sample_left(sl), .sample_right(sr), .sample_valid(sv), .sample_ready(ready),
      .sck(sck), .ws(ws), .sd(sd), .frame_start(fs), .underrun(ur)
   );

   i2s_transmitter #(.NUMBER_OF_BITS(8), .SLOT_BITS(8), .SCK_DIV(1)) dut_lb (
      .clk(clk), .rst_n(rst_n), .en(lb_en),
      .sample_left(lb_l), .sample_right(lb_r), .sample_valid(lb_v), .sample_ready(lb_ready),
      .sck(lb_sck), .ws(lb_ws), .sd(lb_sd), .frame_start(lb_fs), .underrun(lb_ur)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      en = 1'b0; sv = 1'b0; lb_en = 1'b0; lb_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nfs, nur, fs_at, ur_at, first_rise, ws_r, ws_f, nf, idx, sck_hi, nrx, nws;
      logic psck, pws, acc, hit;
      logic [31:0] cap[4], wcap[4];
      int ws_t[4];
      logic [7:0] bl[4], br[4], lbl[16], lbr[16];
      logic [15:0] sreg, rx[16];

      en = 1'b0; sv = 1'b0; sl = '0; sr = '0;
      lb_en = 1'b0; lb_v = 1'b0; lb_l = '0; lb_r = '0;

      // asynchronous reset before any clk edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sck", 32'(sck), 0);
      chk("rst_ws", 32'(ws), 0);
      chk("rst_sd", 32'(sd), 0);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_fs", 32'(fs), 0);
      chk("rst_ur", 32'(ur), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single frame A5/3C followed by one underrun frame
      sl = 8'hA5; sr = 8'h3C; sv = 1'b1; en = 1'b1;
      step();
      chk("acc_ready_low", 32'(ready), 0);
      chk("acc_no_fs", 32'(fs), 0);
      sv = 1'b0;
      step();
      chk("load_fs", 32'(fs), 1);
      chk("load_sd_msb", 32'(sd), 1);
      chk("load_ws", 32'(ws), 0);
      chk("load_sck", 32'(sck), 0);
      chk("load_ready", 32'(ready), 1);
      for (int j = 0; j < 4; j++) begin cap[j] = '0; wcap[j] = '0; end
      k = 0; nfs = 0; nur = 0; fs_at = -1; ur_at = -1; first_rise = -1; ws_r = -1; ws_f = -1;
      psck = sck; pws = ws;
      for (int i = 1; i <= 255; i++) begin
         step();
         if (!psck && sck) begin
            if (k == 0) first_rise = i;
            if (k < 64) begin
               cap[k/32][31-(k%32)]  = sd;
               wcap[k/32][31-(k%32)] = ws;
            end
            k++;
         end
         if (fs) begin nfs++; fs_at = i; end
         if (ur) begin nur++; ur_at = i; end
         if (!pws && ws && ws_r < 0) ws_r = i;
         if (pws && !ws && ws_f < 0) ws_f = i;
         psck = sck; pws = ws;
      end
      chk("first_rise", first_rise, 2);
      chk("f1_sd", cap[0], 32'hA5003C00);
      chk("f1_ws", wcap[0], 32'h0001FFFE);
      chk("f2_sd_zero", cap[1], 32'h0);
      chk("f2_ws", wcap[1], 32'h0001FFFE);
      chk("rise_count", k, 64);
      chk("fs_count", nfs, 1);
      chk("fs_at", fs_at, 128);
      chk("ur_count", nur, 1);
      chk("ur_at", ur_at, 128);
      chk("ws_rise_at", ws_r, 60);
      chk("ws_fall_at", ws_f, 124);

      // back-to-back: four pairs, never an underrun
      do_reset();
      bl = '{8'h12, 8'h9C, 8'hE7, 8'h41};
      br = '{8'hF0, 8'h0F, 8'h88, 8'h7E};
      for (int j = 0; j < 4; j++) cap[j] = '0;
      idx = 0; sl = bl[0]; sr = br[0]; sv = 1'b1; en = 1'b1;
      k = 0; nfs = 0; nur = 0; nws = 0; psck = 1'b0; pws = 1'b0;
      for (int c = 0; c < 700 && k < 128; c++) begin
         acc = sv && ready;
         step();
         if (acc) begin
            idx++;
            if (idx < 4) begin sl = bl[idx]; sr = br[idx]; end
            else sv = 1'b0;
         end
         if (fs) nfs++;
         if (ur) nur++;
         if (nfs > 0 && !psck && sck) begin
            cap[k/32][31-(k%32)] = sd;
            k++;
         end
         if (!pws && ws && nws < 4) begin ws_t[nws] = c; nws++; end
         psck = sck; pws = ws;
      end
      chk("b2b_rises", k, 128);
      chk("b2b_fs", nfs, 4);
      chk("b2b_no_ur", nur, 0);
      chk("b2b_ws_rises", nws, 4);
      for (int j = 1; j < 4; j++) chk($sformatf("b2b_ws_period%0d", j), ws_t[j] - ws_t[j-1], 128);
      for (int j = 0; j < 4; j++) chk($sformatf("b2b_frame%0d", j), cap[j], {bl[j], 8'h00, br[j], 8'h00});

      // en dropped at p=5: frame completes, then IDLE; retained pair restarts cleanly
      do_reset();
      sl = 8'hC3; sr = 8'h5A; sv = 1'b1; en = 1'b1;
      step();
      sv = 1'b0;
      step();
      chk("drop_load_fs", 32'(fs), 1);
      k = 0; nf = 0; nfs = 0; cap[0] = '0; psck = sck;
      for (int i = 1; i <= 128; i++) begin
         acc = sv && ready;
         step();
         if (acc) sv = 1'b0;
         if (!psck && sck && k < 32) begin cap[0][31-k] = sd; k++; end
         if (psck && !sck) begin
            nf++;
            if (nf == 5) begin en = 1'b0; sl = 8'h96; sr = 8'h69; sv = 1'b1; end
         end
         if (fs) nfs++;
         psck = sck;
      end
      chk("drop_frame", cap[0], 32'hC3005A00);
      chk("drop_rises", k, 32);
      chk("drop_no_fs", nfs, 0);
      chk("drop_idle_sck", 32'(sck), 0);
      chk("drop_idle_ws", 32'(ws), 0);
      chk("drop_idle_sd", 32'(sd), 0);
      sck_hi = 0;
      repeat (10) begin
         step();
         if (sck || fs) sck_hi++;
      end
      chk("idle_quiet", sck_hi, 0);
      chk("idle_pair_held", 32'(ready), 0);
      en = 1'b1;
      step();
      chk("restart_fs", 32'(fs), 1);
      chk("restart_sd_msb", 32'(sd), 1);
      chk("restart_ready", 32'(ready), 1);

      // reset mid-run while sck, ws and sd are all high, with the holding register full
      sl = 8'hAA; sr = 8'h55; sv = 1'b1;
      step();
      sv = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (sck && ws && sd) begin hit = 1'b1; break; end
         step();
      end
      chk("midrun_found", 32'(hit), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sck", 32'(sck), 0);
      chk("midrst_ws", 32'(ws), 0);
      chk("midrst_sd", 32'(sd), 0);
      chk("midrst_ready", 32'(ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      nfs = 0; sck_hi = 0;
      repeat (40) begin
         step();
         if (fs) nfs++;
         if (sck) sck_hi++;
      end
      chk("midrst_hold_cleared", nfs, 0);
      chk("midrst_stays_idle", sck_hi, 0);

      // loopback: SCK_DIV=1, SLOT_BITS=8 into a ws-framed receiver model
      do_reset();
      for (int j = 0; j < 16; j++) begin lbl[j] = 8'($urandom); lbr[j] = 8'($urandom); end
      idx = 0; lb_l = lbl[0]; lb_r = lbr[0]; lb_v = 1'b1; lb_en = 1'b1;
      nrx = 0; psck = 1'b0; pws = 1'b0; sreg = '0;
      for (int c = 0; c < 700 && nrx < 16; c++) begin
         acc = lb_v && lb_ready;
         step();
         if (acc) begin
            idx++;
            if (idx < 16) begin lb_l = lbl[idx]; lb_r = lbr[idx]; end
            else lb_v = 1'b0;
         end
         if (!psck && lb_sck) begin
            sreg = {sreg[14:0], lb_sd};
            if (pws && !lb_ws && nrx < 16) begin rx[nrx] = sreg; nrx++; end
            pws = lb_ws;
         end
         psck = lb_sck;
      end
      chk("lb_frames", nrx, 16);
      for (int j = 0; j < 16; j++)
         if (j < nrx) chk($sformatf("lb_pair%0d", j), 32'(rx[j]), 32'({lbl[j], lbr[j]}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes stereo PCM sample pairs onto an I2S bus as bus master, generating SCK, WS and SD from the system clock. Sits on the output side of the beamformer datapath and is the mirror of the I2S receiver: processed left/right samples enter through a valid/ready port and leave as standard Philips I2S. A bench can loop it back into the receiver.

## Interface
- NUMBER_OF_BITS, 8: PCM sample width; must be <= SLOT_BITS, elaboration error otherwise.
- SLOT_BITS, 16: SCK periods per channel slot; frame = 2*SLOT_BITS SCK periods.
- SCK_DIV, 2: clk cycles per SCK half-period, >= 1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- en  in  1  run enable; sampled at frame boundaries.
- sample_left  in  NUMBER_OF_BITS  left PCM sample, two's complement, MSB first on the wire.
- sample_right  in  NUMBER_OF_BITS  right PCM sample.
- sample_valid  in  1  pair offered.
- sample_ready  out  1  holding register empty; accept when valid && ready.
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sd  out  1  serial data; changes only on sck falling edge.
- frame_start  out  1  one-clk pulse when a pair (or underrun zeros) is loaded into the shifters.
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty.

## Operation
- Holding register: one stereo pair plus full flag. sample_ready = !full, registered. Accept sets full; load into shifters clears it. No same-cycle accept and load: ready is low while full.
- States: IDLE, RUN.
- IDLE: sck=0, ws=0, sd=0, divider and position counter held at 0. Go to RUN when en=1 and full=1; the transition cycle loads the holding pair and pulses frame_start.
- RUN: divider counts 0..SCK_DIV-1; at terminal count sck toggles. A falling tick (sck 1->0) advances slot position p, 0..2*SLOT_BITS-1, wrapping.
- SD at position p: p < NUMBER_OF_BITS -> left bit [NUMBER_OF_BITS-1-p]; SLOT_BITS <= p < SLOT_BITS+NUMBER_OF_BITS -> right bit [NUMBER_OF_BITS-1-(p-SLOT_BITS)]; otherwise 0.
- WS at position p = ((p+1) mod 2*SLOT_BITS) >= SLOT_BITS. WS therefore changes one SCK period before each MSB, per I2S.
- Frame boundary (falling tick wrapping p to 0):
  - en=0 -> IDLE.
  - else full=1 -> load the pair, frame_start.
  - else load zeros, frame_start and underrun in the same cycle.
- en deassert mid-frame: the frame completes, then the block goes to IDLE. The holding pair is retained.

## Timing
- Reset values: sck=0, ws=0, sd=0, sample_ready=1, frame_start=0, underrun=0, state IDLE, holding empty. All take effect immediately on rst_n low, with no clk edge needed.
- Accept at edge N: sample_ready low from N+1. In IDLE with en=1, RUN and load at N+1 and sample_ready high again at N+2.
- Load cycle: sd = left MSB and ws=0 in the same registered cycle. First sck rise SCK_DIV cycles later; first fall 2*SCK_DIV cycles later.
- Frame period: 4*SLOT_BITS*SCK_DIV clk cycles (128 at defaults). ws toggles every 2*SLOT_BITS*SCK_DIV clk cycles.
- sd and ws are registered and updated in the same cycle sck falls, which guarantees half an SCK period of setup for the receiver's rising-edge sampling.
- Counter widths: p uses $clog2(2*SLOT_BITS) bits; the divider uses $clog2(SCK_DIV)+1 bits.

## Structure
- Shared package i2s_pkg holds:
  - default NUMBER_OF_BITS and SLOT_BITS constants, also used by the receiver;
  - the state enum (IDLE, RUN);
  - the WS polarity constants (LEFT=0, RIGHT=1).
- One sub-module, i2s_clock_gen: the divider. It produces sck plus one-clk rise/fall tick strobes and is held at 0 while disabled. The receiver's slave-mode tests can reuse it.

## Test plan
- Reset: drive rst_n=0 mid-run, with no clk edge -> sck=ws=sd=0, sample_ready=1, no pulses; holding cleared.
- Single frame, defaults: L=8'hA5, R=8'h3C, en=1. Required:
  - sd on successive falls reads 10100101, 8 zeros, 00111100, 8 zeros;
  - ws rises at p=15 and falls at p=31;
  - one frame_start; frame is 128 clk.
- Back-to-back: offer a new pair whenever sample_ready is high, for 4 frames -> each frame carries its own pair, underrun never pulses, and ws period is a constant 128 clk.
- Underrun: one pair, then none -> frame 2 sd all zeros; underrun and frame_start pulse together once at the frame-2 boundary; sck and ws continue uninterrupted.
- en drop: en=0 at p=5 -> frame completes through p=31, then IDLE with sck=0, ws=0; re-assert en with holding full -> a new frame starts cleanly.
- Loopback with SCK_DIV=1 and SLOT_BITS=8 into the receiver -> recovered left/right equal the transmitted pairs for 16 random frames.
